ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage of the npc single-issue core.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request plus valid response channel.
- Buffers one returned instruction and presents it downstream as {pc, inst} with valid/ready; the downstream consumer is the decode and simulation-control stage that ends simulation on EBREAK.
- Supports control-flow redirects. After delivering EBREAK (32'h00100073) it stops fetching.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- EBREAK_INST, 32'h00100073, encoding that halts fetch once delivered.

Ports:
- clock, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous, active-high.
- imem_req_valid, output, 1, fetch request valid.
- imem_req_ready, input, 1, memory accepts the request.
- imem_req_addr, output, 32, word-aligned fetch address.
- imem_rsp_valid, input, 1, response data valid for one cycle.
- imem_rsp_data, input, 32, fetched instruction.
- out_valid, output, 1, instruction available downstream.
- out_ready, input, 1, downstream accepts.
- out_pc, output, 32, PC of the presented instruction.
- out_inst, output, 32, presented instruction.
- redirect_valid, input, 1, control-flow redirect, single-cycle pulse.
- redirect_pc, input, 32, redirect target.
- halted, output, 1, EBREAK delivered; fetch stopped.

Behaviour:
- Reset values (next edge with reset=1):
  - state=REQ, pc=RESET_PC, drop=0, inst_buf=0.
  - Outputs: out_valid=0, halted=0, out_inst=0, out_pc=RESET_PC.
  - imem_req_valid=1 from the first cycle after reset.
- Reset has priority over every other input in every state, including mid-WAIT. A memory response arriving after reset is treated as stray and ignored in REQ.
- Registers: pc[31:0], inst_buf[31:0], drop, 2-bit state.
- The two low bits of redirect_pc are forced to 0 when loaded into pc.
- imem_req_addr = pc at all times. out_pc = pc. out_inst = inst_buf.
- States:
  - REQ: imem_req_valid=1.
    - req_ready=1 -> WAIT.
    - redirect in the same cycle as acceptance -> pc<=redirect_pc, drop<=1, WAIT.
    - redirect without acceptance -> pc<=redirect_pc, stay in REQ. The address changes the next cycle, which is legal because the request was not accepted.
    - imem_rsp_valid in REQ is ignored.
  - WAIT: imem_req_valid=0, at most one outstanding request.
    - rsp_valid with drop=1 -> discard the data, drop<=0, go to REQ.
    - rsp_valid with drop=0 and no redirect -> inst_buf<=rsp_data, go to OUT.
    - redirect with no rsp_valid -> pc<=redirect_pc, drop<=1, stay in WAIT.
    - redirect together with rsp_valid -> discard the data, pc<=redirect_pc, drop<=0, go to REQ.
  - OUT: out_valid=1. pc and inst_buf are held stable while out_ready=0.
    - out_ready=1, no redirect, inst_buf==EBREAK_INST -> HALT.
    - out_ready=1, no redirect, any other instruction -> pc<=pc+4 (mod 2^32, wraps 32'hFFFFFFFC->0), go to REQ.
    - redirect (regardless of out_ready) -> pc<=redirect_pc, go to REQ.
      - If out_ready was also 1, the handshake still counts as delivered.
      - If that delivered instruction is EBREAK, HALT takes priority and the redirect is ignored.
  - HALT: absorbing until reset.
    - halted=1, out_valid=0, imem_req_valid=0.
    - Redirects and responses are ignored.
- Latency and throughput:
  - Request-accept to out_valid is 1 cycle after rsp_valid.
  - Minimum of 3 cycles per instruction: REQ -> WAIT -> OUT.

Test Plan:
- Reset, then imem_req_ready=1 always and rsp_valid one cycle after each accept with data 0x00000013 -> imem_req_addr sequence is 0x80000000, 0x80000004, 0x80000008; out_pc matches each; out_inst=0x00000013.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1, out_pc/out_inst stable, imem_req_valid=0; release -> next request goes to pc+4.
- Redirect in WAIT to 0x80000102: the old response (0xDEADBEEF) is dropped and never shown; the next request uses addr 0x80000100; out_pc=0x80000100.
- Redirect coincident with out handshake, target 0x80001000 -> the instruction counts as delivered once; next imem_req_addr=0x80001000, not pc+4.
- Deliver 0x00100073 at pc 0x8000000C with out_ready=1 -> halted=1 the next cycle; no further imem_req_valid or out_valid for 20 cycles, even with redirect pulses.
- Assert reset during WAIT, with a stray rsp_valid of 0x11111111 the next cycle -> the response is ignored; imem_req_addr=0x80000000; halted=0; out_valid=0.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage of the npc single-issue core.
// Holds the PC and issues one word fetch at a time to instruction memory.
// It buffers the returned word and presents {pc, inst} downstream.
// Redirects retarget the PC.
// Once EBREAK has been delivered downstream, fetch stops until reset.
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   imem_req_valid/ready  fetch request handshake
//   imem_req_addr         word-aligned fetch address (always the PC)
//   imem_rsp_valid/data   single-cycle fetch response
//   out_valid/ready       downstream handshake
//   out_pc, out_inst      presented instruction and its PC
//   redirect_valid/pc     single-cycle control-flow redirect
//   halted                EBREAK delivered, fetch stopped
//
// state  | meaning
// -------+---------------------------------------------------------
// S_REQ  | request for pc presented to memory
// S_WAIT | request accepted, waiting for the response
// S_OUT  | buffered instruction presented downstream
// S_HALT | EBREAK delivered; absorbing until reset

module ifu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst_buf;
  logic        r_drop;

  logic [31:0] w_redir_pc;
  logic        w_is_ebreak;

  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};
  assign w_is_ebreak = (r_inst_buf == EBREAK_INST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_inst_buf <= 32'd0;
      r_drop     <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          // A redirect may move the address only because the request for
          // the old pc was either not accepted or will be dropped.
          if (redirect_valid)
            r_pc <= w_redir_pc;
          if (imem_req_ready) begin
            r_state <= S_WAIT;
            r_drop  <= redirect_valid;
          end
        end

        S_WAIT: begin
          if (imem_rsp_valid) begin
            // The outstanding request completes here, so no drop is
            // needed afterwards even if a redirect arrives together.
            r_drop <= 1'b0;
            if (redirect_valid) begin
              r_pc    <= w_redir_pc;
              r_state <= S_REQ;
            end else if (r_drop) begin
              r_state <= S_REQ;
            end else begin
              r_inst_buf <= imem_rsp_data;
              r_state    <= S_OUT;
            end
          end else if (redirect_valid) begin
            r_pc   <= w_redir_pc;
            r_drop <= 1'b1;
          end
        end

        S_OUT: begin
          // A delivered EBREAK wins over any coincident redirect.
          if (out_ready && w_is_ebreak) begin
            r_state <= S_HALT;
          end else if (redirect_valid) begin
            r_pc    <= w_redir_pc;
            r_state <= S_REQ;
          end else if (out_ready) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_REQ;
          end
        end

        S_HALT: begin
          r_state <= S_HALT;
        end

        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  // Outputs decode directly from the state flops (no input-to-output paths).
  assign imem_req_valid = (r_state == S_REQ);
  assign out_valid      = (r_state == S_OUT);
  assign halted         = (r_state == S_HALT);
  assign imem_req_addr  = r_pc;
  assign out_pc         = r_pc;
  assign out_inst       = r_inst_buf;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Scoreboard of {pc, inst} expected at the downstream handshake.
  logic [63:0] sb[$];

  ifu_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    reset          = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One full REQ -> WAIT -> OUT transaction; optional backpressure and a
  // redirect coincident with the downstream handshake.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int hold,
                       input logic redir, input logic [31:0] rpc);
    logic [63:0] e;
    chk1("req_valid", imem_req_valid, 1'b1);
    chk("req_addr", imem_req_addr, a);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk1("wait_req_valid", imem_req_valid, 1'b0);
    chk1("wait_out_valid", out_valid, 1'b0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = d;
    sb.push_back({a, d});
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    for (int i = 0; i < hold; i++) begin
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_req_valid", imem_req_valid, 1'b0);
      chk("bp_out_pc", out_pc, a);
      chk("bp_out_inst", out_inst, d);
      step();
    end
    out_ready      = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    chk1("out_valid", out_valid, 1'b1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=%0d expected=1", sb.size());
    end else begin
      e = sb.pop_front();
      chk("out_pc", out_pc, e[63:32]);
      chk("out_inst", out_inst, e[31:0]);
    end
    step();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    chk1("rst_req_valid", imem_req_valid, 1'b1);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk("rst_out_pc", out_pc, 32'h8000_0000);
    chk("rst_out_inst", out_inst, 32'd0);

    // Sequential fetch, then backpressure on the third instruction.
    fetch(32'h8000_0000, NOP, 0, 1'b0, 32'd0);
    fetch(32'h8000_0004, NOP, 0, 1'b0, 32'd0);
    fetch(32'h8000_0008, 32'h0000_0093, 5, 1'b0, 32'd0);

    // Redirect in WAIT: the old response is dropped.
    chk("seq_req_addr", imem_req_addr, 32'h8000_000C);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    chk1("wr_req_valid", imem_req_valid, 1'b0);
    chk("wr_pc", out_pc, 32'h8000_0100);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk1("drop_out_valid", out_valid, 1'b0);
    chk1("drop_req_valid", imem_req_valid, 1'b1);

    // Redirect coincident with the downstream handshake.
    fetch(32'h8000_0100, 32'h0050_0093, 0, 1'b1, 32'h8000_1000);
    chk1("rh_req_valid", imem_req_valid, 1'b1);
    chk("rh_req_addr", imem_req_addr, 32'h8000_1000);
    chk1("rh_out_valid", out_valid, 1'b0);
    chk("rh_sb_size", 32'(sb.size()), 32'd0);

    // Redirect together with a response in WAIT.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_2222;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    chk1("wrr_out_valid", out_valid, 1'b0);
    chk1("wrr_req_valid", imem_req_valid, 1'b1);
    chk("wrr_req_addr", imem_req_addr, 32'h8000_2000);

    // Redirect in REQ without acceptance; low bits forced; pc wraps.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    fetch(32'hFFFF_FFFC, NOP, 0, 1'b0, 32'd0);
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_000C;
    step();
    redirect_valid = 1'b0;

    // EBREAK delivery halts fetch.
    fetch(32'h8000_000C, EBREAK, 0, 1'b0, 32'd0);
    chk1("halted", halted, 1'b1);
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i % 4 == 0);
      redirect_pc    = 32'h8000_4000;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = NOP;
      step();
      chk1("halt_req_valid", imem_req_valid, 1'b0);
      chk1("halt_out_valid", out_valid, 1'b0);
      chk1("halt_halted", halted, 1'b1);
    end

    // Reset during WAIT with a stray response right after.
    do_reset();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk1("rw_req_valid", imem_req_valid, 1'b0);
    reset = 1'b1;
    step();
    reset          = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    step();
    imem_rsp_valid = 1'b0;
    chk1("rw_req_valid2", imem_req_valid, 1'b1);
    chk("rw_req_addr", imem_req_addr, 32'h8000_0000);
    chk1("rw_halted", halted, 1'b0);
    chk1("rw_out_valid", out_valid, 1'b0);
    chk("rw_out_inst", out_inst, 32'd0);
    fetch(32'h8000_0000, NOP, 0, 1'b0, 32'd0);
    chk("rw_next_addr", imem_req_addr, 32'h8000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
